// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU defaults and the queue occupancy-width helper
package cpu_pkg;

  localparam int          WORD_SIZE_DEF = 16;
  localparam int unsigned RESET_PC_DEF  = 0;

  // Counter width able to hold every value from 0 up to and including depth.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// rtl/prefetch_fifo.sv - instruction queue storage, pointers and occupancy count
module prefetch_fifo
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  input  logic                        flush,
  output logic [WIDTH-1:0]            head_data,
  output logic [occ_width(DEPTH)-1:0] count,
  output logic                        empty,
  output logic                        full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = occ_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // Pointers are exactly log2(DEPTH) wide, so increments wrap modulo DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/prefetch_unit.sv
// rtl/prefetch_unit.sv - instruction prefetch: fetch PC, request control, queue and counters
module prefetch_unit
  import cpu_pkg::*;
#(
  parameter int                   WORD_SIZE = WORD_SIZE_DEF,
  parameter int                   DEPTH     = 4,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = WORD_SIZE'(RESET_PC_DEF)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  output logic                        readM1,
  output logic [WORD_SIZE-1:0]        address1,
  input  logic [WORD_SIZE-1:0]        data1,
  input  logic                        mem_ready,
  output logic [WORD_SIZE-1:0]        id_instr,
  output logic [WORD_SIZE-1:0]        id_pc1,
  output logic                        id_valid,
  input  logic                        id_stall,
  input  logic                        redirect,
  input  logic [WORD_SIZE-1:0]        redirect_pc,
  input  logic                        halt,
  output logic [occ_width(DEPTH)-1:0] occupancy,
  output logic [WORD_SIZE-1:0]        num_fetch,
  output logic [WORD_SIZE-1:0]        num_flush
);

  logic [WORD_SIZE-1:0]   fetch_pc;
  logic [2*WORD_SIZE-1:0] head_data;
  logic                   empty;
  logic                   full;
  logic                   fetch;
  logic                   pop;

  // No id_stall term here: the request depends only on registered fullness.
  assign readM1   = ~full & ~halt & ~redirect;
  assign fetch    = readM1 & mem_ready;
  assign address1 = fetch_pc;
  assign id_valid = ~empty & ~redirect;
  assign pop      = id_valid & ~id_stall;
  assign id_instr = head_data[2*WORD_SIZE-1:WORD_SIZE];
  assign id_pc1   = head_data[WORD_SIZE-1:0];

  prefetch_fifo #(
    .WIDTH (2 * WORD_SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fetch),
    .push_data ({data1, fetch_pc + WORD_SIZE'(1)}),
    .pop       (pop),
    .flush     (redirect),
    .head_data (head_data),
    .count     (occupancy),
    .empty     (empty),
    .full      (full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc  <= RESET_PC;
      num_fetch <= '0;
      num_flush <= '0;
    end else if (redirect) begin
      fetch_pc  <= redirect_pc;
      num_flush <= num_flush + WORD_SIZE'(occupancy);
    end else if (fetch) begin
      fetch_pc  <= fetch_pc + WORD_SIZE'(1);
      num_fetch <= num_fetch + WORD_SIZE'(1);
    end
  end

endmodule
